mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register and write-back stage of the 5-stage MIPS pipeline. Sits directly

---
 rtl/mem_wb_stage.sv | 89 ++++++++
 tb/tb_mem_wb_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage. It also holds a one-entry bypass of the
// last retired write and a saturating count of retired instructions.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              cntClear,
    input  logic              validIn,
    input  logic              regWriteIn,
    input  logic              memToRegIn,
    input  logic [REG_W-1:0]  destIn,
    input  logic [DATA_W-1:0] memOutIn,
    input  logic [DATA_W-1:0] addressOrResIn,
    output logic              regWrite,
    output logic [REG_W-1:0]  writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              wbValid,
    output logic              prevWrite,
    output logic [REG_W-1:0]  prevReg,
    output logic [DATA_W-1:0] prevData,
    output logic [CNT_W-1:0]  retireCount
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] mem_out;
        logic [DATA_W-1:0] res;
    } wb_regs_t;

    wb_regs_t wb_q;
    logic     retire;

    // A flush ejects the instruction even when the stage is stalled, so it still retires.
    assign retire = wb_q.valid & (~stall | flush);

    assign writeData = wb_q.mem_to_reg ? wb_q.mem_out : wb_q.res;
    assign writeReg  = wb_q.dest;
    assign regWrite  = wb_q.reg_write & wb_q.valid;
    assign wbValid   = wb_q.valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
        end else if (flush) begin
            wb_q.valid     <= 1'b0;
            wb_q.reg_write <= 1'b0;
        end else if (!stall) begin
            wb_q.valid      <= validIn;
            wb_q.reg_write  <= regWriteIn & validIn & (destIn != '0);
            wb_q.mem_to_reg <= memToRegIn;
            wb_q.dest       <= destIn;
            wb_q.mem_out    <= memOutIn;
            wb_q.res        <= addressOrResIn;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevWrite <= 1'b0;
            prevReg   <= '0;
            prevData  <= '0;
        end else if (retire) begin
            prevWrite <= regWrite;
            prevReg   <= writeReg;
            prevData  <= writeData;
        end else if (!stall || flush) begin
            prevWrite <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retireCount <= '0;
        end else if (cntClear) begin
            retireCount <= '0;
        end else if (retire && (retireCount != {CNT_W{1'b1}})) begin
            retireCount <= retireCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage (CNT_W=4 so saturation is reachable).
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush, cntClear, validIn, regWriteIn, memToRegIn;
    logic [RW-1:0] destIn;
    logic [DW-1:0] memOutIn, addressOrResIn;
    logic          regWrite, wbValid, prevWrite;
    logic [RW-1:0] writeReg, prevReg;
    logic [DW-1:0] writeData, prevData;
    logic [CW-1:0] retireCount;

    mem_wb_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cntClear(cntClear),
        .validIn(validIn), .regWriteIn(regWriteIn), .memToRegIn(memToRegIn),
        .destIn(destIn), .memOutIn(memOutIn), .addressOrResIn(addressOrResIn),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData), .wbValid(wbValid),
        .prevWrite(prevWrite), .prevReg(prevReg), .prevData(prevData), .retireCount(retireCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rw;
        logic [RW-1:0] wr;
        logic [DW-1:0] wd;
        logic          wv;
        logic          pw;
        logic [RW-1:0] pr;
        logic [DW-1:0] pd;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // reference model state
    logic          m_v, m_rw, m_m2r;
    logic [RW-1:0] m_d;
    logic [DW-1:0] m_mo, m_res;
    logic          m_pw;
    logic [RW-1:0] m_pr;
    logic [DW-1:0] m_pd;
    logic [CW-1:0] m_cnt;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_v = 0; m_rw = 0; m_m2r = 0; m_d = '0; m_mo = '0; m_res = '0;
        m_pw = 0; m_pr = '0; m_pd = '0; m_cnt = '0;
    endtask

    task automatic step(input logic v, input logic rwi, input logic m2r, input logic [RW-1:0] d,
                        input logic [DW-1:0] mo, input logic [DW-1:0] res,
                        input logic st, input logic fl, input logic clr);
        logic          r, rw_o;
        logic [DW-1:0] wd_o;
        exp_t          e, got;
        validIn = v; regWriteIn = rwi; memToRegIn = m2r; destIn = d;
        memOutIn = mo; addressOrResIn = res; stall = st; flush = fl; cntClear = clr;
        r    = m_v & (~st | fl);
        rw_o = m_rw & m_v;
        wd_o = m_m2r ? m_mo : m_res;
        if (r) begin
            m_pw = rw_o; m_pr = m_d; m_pd = wd_o;
        end else if (!st || fl) begin
            m_pw = 1'b0;
        end
        if (clr) m_cnt = '0;
        else if (r && m_cnt != 4'hF) m_cnt = m_cnt + 1'b1;
        if (fl) begin
            m_v = 0; m_rw = 0;
        end else if (!st) begin
            m_v = v; m_rw = rwi & v & (d != 0); m_m2r = m2r; m_d = d; m_mo = mo; m_res = res;
        end
        e.rw = m_rw & m_v; e.wr = m_d; e.wd = m_m2r ? m_mo : m_res; e.wv = m_v;
        e.pw = m_pw; e.pr = m_pr; e.pd = m_pd; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            got = sb.pop_front();
            chk("regWrite",    regWrite,    got.rw);
            chk("writeReg",    writeReg,    got.wr);
            chk("writeData",   writeData,   got.wd);
            chk("wbValid",     wbValid,     got.wv);
            chk("prevWrite",   prevWrite,   got.pw);
            chk("prevReg",     prevReg,     got.pr);
            chk("prevData",    prevData,    got.pd);
            chk("retireCount", retireCount, got.cnt);
        end
    endtask

    task automatic bubble();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        stall = 0; flush = 0; cntClear = 0; validIn = 0; regWriteIn = 0; memToRegIn = 0;
        destIn = '0; memOutIn = '0; addressOrResIn = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regWrite", regWrite, 0);
        chk("rst_writeData", writeData, 0);
        chk("rst_wbValid", wbValid, 0);
        chk("rst_count", retireCount, 0);
        rst = 1'b0;

        // ALU op, then its bypass entry
        step(1, 1, 0, 8, 32'h0, 32'h1234, 0, 0, 0);
        chk("alu_regWrite", regWrite, 1);
        chk("alu_writeReg", writeReg, 8);
        chk("alu_writeData", writeData, 32'h1234);
        bubble();
        chk("alu_prevWrite", prevWrite, 1);
        chk("alu_prevData", prevData, 32'h1234);
        chk("alu_count", retireCount, 1);

        // load selects memory data
        step(1, 1, 1, 9, 32'hDEADBEEF, 32'h40, 0, 0, 0);
        chk("ld_writeData", writeData, 32'hDEADBEEF);

        // $0 destination never written but still retires
        step(1, 1, 0, 0, 0, 32'h99, 0, 0, 0);
        chk("r0_regWrite", regWrite, 0);
        chk("r0_count", retireCount, 2);

        // stall holds WB for 3 cycles, counts once after release
        step(1, 1, 0, 5, 0, 32'h55, 0, 0, 0);
        chk("st_pre_count", retireCount, 3);
        repeat (3) begin
            step(1, 1, 0, 6, 0, 32'h66, 1, 0, 0);
            chk("st_writeData", writeData, 32'h55);
            chk("st_writeReg", writeReg, 5);
            chk("st_count", retireCount, 3);
        end
        step(1, 1, 0, 7, 0, 32'h77, 0, 0, 0);
        chk("st_rel_writeData", writeData, 32'h77);
        chk("st_rel_count", retireCount, 4);

        // flush overrides stall
        step(1, 1, 0, 10, 0, 32'hAA, 1, 1, 0);
        chk("fl_wbValid", wbValid, 0);
        chk("fl_regWrite", regWrite, 0);
        chk("fl_count", retireCount, 5);

        // saturation
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("clr_count", retireCount, 0);
        for (int i = 0; i < 18; i++) step(1, 1, 0, 5'(i + 1), 0, 32'(i), 0, 0, 0);
        chk("sat_count", retireCount, 4'hF);
        step(1, 1, 0, 3, 0, 32'h3, 0, 0, 1);
        chk("sat_clr_count", retireCount, 0);

        // random traffic
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                 5'($urandom_range(0, 31)), $urandom, $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        end

        // async reset between edges while stalled and flushing
        step(1, 1, 0, 12, 0, 32'hC0FFEE, 0, 0, 0);
        stall = 1; flush = 1;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_regWrite", regWrite, 0);
        chk("arst_writeReg", writeReg, 0);
        chk("arst_writeData", writeData, 0);
        chk("arst_wbValid", wbValid, 0);
        chk("arst_prevWrite", prevWrite, 0);
        chk("arst_count", retireCount, 0);
        #2;
        rst = 1'b0;
        step(1, 1, 0, 4, 0, 32'h44, 0, 0, 0);
        chk("post_rst_writeData", writeData, 32'h44);
        bubble();
        chk("post_rst_count", retireCount, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
